// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-only synchronous RAM.
// Sub-word stores use read-modify-write; misaligned or out-of-range requests error out without touching the RAM.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    typedef enum logic [2:0] {IDLE, ERR, READ, LOAD, WRITE, RMW_RD, RMW_WR} state_t;

    state_t            state, state_next;
    logic              we_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              accept, bad;
    logic [4:0]        shift;
    logic [31:0]       dout_sh, merged, load_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign accept = req_valid && req_ready;
    assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_addr[31:ADDR_W+2] != '0;

    // Big-endian: byte offset 0 lives in the top lane, so shift by (3 - offset) bytes
    assign shift     = {~addr_q[1:0], 3'b000};
    assign dout_sh   = ram_dout >> shift;
    assign lane_b    = dout_sh[7:0];
    assign lane_h    = addr_q[1] ? ram_dout[15:0] : ram_dout[31:16];
    assign load_data = size_q == 2'b00 ? {{24{signed_q & lane_b[7]}}, lane_b} :
                       size_q == 2'b01 ? {{16{signed_q & lane_h[15]}}, lane_h} : ram_dout;
    assign merged    = size_q == 2'b00 ? (ram_dout & ~(32'hff << shift)) | ({24'b0, wdata_q[7:0]} << shift) :
                       addr_q[1] ? {ram_dout[31:16], wdata_q[15:0]} : {wdata_q[15:0], ram_dout[15:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr[ADDR_W+1:0];
                wdata_q  <= req_wdata;
            end
            if (state == LOAD) resp_rdata <= load_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bad ? ERR : !req_we ? READ : req_size == 2'b10 ? WRITE : RMW_RD;
            READ:    state_next = LOAD;
            RMW_RD:  state_next = RMW_WR;
            default: state_next = IDLE;
        endcase
    end

    // Reset gates the write strobe and the response so an abandoned RMW leaves no trace
    assign req_ready  = state == IDLE;
    assign resp_valid = !rst && (state == ERR || state == LOAD || state == WRITE || state == RMW_WR);
    assign resp_err   = !rst && state == ERR;
    assign ram_we     = !rst && (state == WRITE || state == RMW_WR);
    assign ram_addr   = addr_q[ADDR_W+1:2];
    assign ram_din    = state == WRITE ? wdata_q : state == RMW_WR ? merged : '0;

    logic unused;
    assign unused = we_q;
endmodule
